// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-side hazard controller interface
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic              id_rs1_ena;
  logic [REG_AW-1:0] id_rs1_addr;
  logic              id_rs2_ena;
  logic [REG_AW-1:0] id_rs2_addr;
  logic              id_rd_ena;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_mem_rd;
  logic              ex_redirect;
  logic              mem_busy;
  logic              pc_stall;
  logic              id_stall;
  logic              ex_bubble;
  logic              id_flush;
  logic              if_kill;
  logic              pipe_hold;
  logic [1:0]        fwd_rs1;
  logic [1:0]        fwd_rs2;
  logic [1:0]        ctrl_state;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1_ena, id_rs1_addr, id_rs2_ena, id_rs2_addr,
           id_rd_ena, id_rd_addr, id_mem_rd, ex_redirect, mem_busy,
    input  pc_stall, id_stall, ex_bubble, id_flush, if_kill, pipe_hold,
           fwd_rs1, fwd_rs2, ctrl_state, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1_ena, id_rs1_addr, id_rs2_ena, id_rs2_addr,
           id_rd_ena, id_rd_addr, id_mem_rd, ex_redirect, mem_busy,
    output pc_stall, id_stall, ex_bubble, id_flush, if_kill, pipe_hold,
           fwd_rs1, fwd_rs2, ctrl_state, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipe scoreboard, interlock, redirect and forwarding control
module pipe_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } state_t;

  sb_entry_t        r_ex, r_mem, r_wb;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs1_ex, w_rs1_mem, w_rs1_wb, w_rs2_ex, w_rs2_mem, w_rs2_wb;
  logic w_lu_haz, w_issue, w_in_flush;
  logic w_pc_stall, w_id_stall, w_ex_bubble, w_id_flush, w_if_kill, w_pipe_hold;
  logic [1:0] w_fwd_rs1, w_fwd_rs2;

  function automatic logic hit(sb_entry_t e, logic ena, logic [REG_AW-1:0] addr);
    return ena & e.v & (e.rd != '0) & (e.rd == addr);
  endfunction

  // A load still in EX has no result yet, so its hit suppresses forwarding entirely.
  function automatic logic [1:0] fwd_sel(logic h_ex, logic h_mem, logic h_wb, logic ex_ld);
    if (h_ex)       return ex_ld ? 2'b00 : 2'b01;
    else if (h_mem) return 2'b10;
    else if (h_wb)  return 2'b11;
    else            return 2'b00;
  endfunction

  assign w_rs1_ex  = hit(r_ex,  bus.id_rs1_ena, bus.id_rs1_addr);
  assign w_rs1_mem = hit(r_mem, bus.id_rs1_ena, bus.id_rs1_addr);
  assign w_rs1_wb  = hit(r_wb,  bus.id_rs1_ena, bus.id_rs1_addr);
  assign w_rs2_ex  = hit(r_ex,  bus.id_rs2_ena, bus.id_rs2_addr);
  assign w_rs2_mem = hit(r_mem, bus.id_rs2_ena, bus.id_rs2_addr);
  assign w_rs2_wb  = hit(r_wb,  bus.id_rs2_ena, bus.id_rs2_addr);

  assign w_lu_haz   = r_ex.ld & (w_rs1_ex | w_rs2_ex);
  assign w_in_flush = (r_state == FLUSH);
  assign w_issue    = bus.id_valid & bus.id_rd_ena & ~w_lu_haz & ~bus.ex_redirect & ~w_in_flush;

  always_comb begin
    w_pc_stall  = 1'b0;
    w_id_stall  = 1'b0;
    w_ex_bubble = 1'b0;
    w_id_flush  = 1'b0;
    w_if_kill   = 1'b0;
    w_pipe_hold = 1'b0;
    w_fwd_rs1   = 2'b00;
    w_fwd_rs2   = 2'b00;
    w_state_nxt = RUN;
    if (rst) begin
      w_fwd_rs1 = fwd_sel(w_rs1_ex, w_rs1_mem, w_rs1_wb, r_ex.ld);
      w_fwd_rs2 = fwd_sel(w_rs2_ex, w_rs2_mem, w_rs2_wb, r_ex.ld);
      if (bus.mem_busy) begin
        w_pipe_hold = 1'b1;
        w_pc_stall  = 1'b1;
        w_id_stall  = 1'b1;
        w_state_nxt = MEM_WAIT;
      end else if (bus.ex_redirect) begin
        w_id_flush  = 1'b1;
        w_ex_bubble = 1'b1;
        w_state_nxt = FLUSH;
      end else if (w_in_flush) begin
        w_if_kill   = 1'b1;
        w_ex_bubble = 1'b1;
        w_state_nxt = w_lu_haz ? LU_STALL : RUN;
      end else if (w_lu_haz) begin
        w_pc_stall  = 1'b1;
        w_id_stall  = 1'b1;
        w_ex_bubble = 1'b1;
        w_state_nxt = LU_STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_id_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!bus.mem_busy) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= w_issue ? {1'b1, bus.id_rd_addr, bus.id_mem_rd} : '0;
      end
    end
  end

  assign bus.pc_stall   = w_pc_stall;
  assign bus.id_stall   = w_id_stall;
  assign bus.ex_bubble  = w_ex_bubble;
  assign bus.id_flush   = w_id_flush;
  assign bus.if_kill    = w_if_kill;
  assign bus.pipe_hold  = w_pipe_hold;
  assign bus.fwd_rs1    = w_fwd_rs1;
  assign bus.fwd_rs2    = w_fwd_rs2;
  assign bus.ctrl_state = r_state;
  assign bus.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vectors, saturation sequence and randomized model check
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32), .REG_AW(5)) ifm ();
  pipe_hazard_ctrl_if #(.CNT_W(4),  .REG_AW(5)) ifs ();

  pipe_hazard_ctrl #(.CNT_W(32), .REG_AW(5)) u_dut (.clk(clk), .rst(rst), .bus(ifm.slave));
  pipe_hazard_ctrl #(.CNT_W(4),  .REG_AW(5)) u_sat (.clk(clk), .rst(rst), .bus(ifs.slave));

  assign ifs.id_valid    = ifm.id_valid;
  assign ifs.id_rs1_ena  = ifm.id_rs1_ena;
  assign ifs.id_rs1_addr = ifm.id_rs1_addr;
  assign ifs.id_rs2_ena  = ifm.id_rs2_ena;
  assign ifs.id_rs2_addr = ifm.id_rs2_addr;
  assign ifs.id_rd_ena   = ifm.id_rd_ena;
  assign ifs.id_rd_addr  = ifm.id_rd_addr;
  assign ifs.id_mem_rd   = ifm.id_mem_rd;
  assign ifs.ex_redirect = ifm.ex_redirect;
  assign ifs.mem_busy    = ifm.mem_busy;

  int total = 0;
  int bad   = 0;

  // flags order: {pc_stall, id_stall, ex_bubble, id_flush, if_kill, pipe_hold}
  typedef struct {
    logic       r, v, e1;
    logic [4:0] a1;
    logic       e2;
    logic [4:0] a2;
    logic       rde;
    logic [4:0] rd;
    logic       ld, redir, busy;
    logic [5:0] flags;
    logic [1:0] f1, f2, st;
    int         cnt;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } slot_t;
  slot_t  sb[3];
  int     m_state;
  longint m_cnt;
  int     m_cnt4;

  task automatic addv(input logic r, v, e1, input int a1, input logic e2, input int a2,
                      input logic rde, input int rd, input logic ld, redir, busy,
                      input logic [5:0] flags, input int f1, f2, st, cnt);
    vec_t t;
    t.r = r; t.v = v; t.e1 = e1; t.a1 = 5'(a1); t.e2 = e2; t.a2 = 5'(a2);
    t.rde = rde; t.rd = 5'(rd); t.ld = ld; t.redir = redir; t.busy = busy;
    t.flags = flags; t.f1 = 2'(f1); t.f2 = 2'(f2); t.st = 2'(st); t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, v, e1, input logic [4:0] a1, input logic e2,
                       input logic [4:0] a2, input logic rde, input logic [4:0] rd,
                       input logic ld, redir, busy);
    rst = r;
    ifm.id_valid = v;     ifm.id_rs1_ena = e1;  ifm.id_rs1_addr = a1;
    ifm.id_rs2_ena = e2;  ifm.id_rs2_addr = a2; ifm.id_rd_ena = rde;
    ifm.id_rd_addr = rd;  ifm.id_mem_rd = ld;   ifm.ex_redirect = redir;
    ifm.mem_busy = busy;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_flags();
    return {ifm.pc_stall, ifm.id_stall, ifm.ex_bubble, ifm.id_flush, ifm.if_kill, ifm.pipe_hold};
  endfunction

  function automatic bit hitm(int k, bit ena, bit [4:0] a);
    return ena && sb[k].v && (sb[k].rd != 0) && (sb[k].rd == a);
  endfunction

  // Youngest producer wins; slot k (0=EX) forwards with code k+1 except an unfinished load.
  function automatic bit [1:0] fwdm(bit ena, bit [4:0] a);
    if (hitm(0, ena, a)) return sb[0].ld ? 2'd0 : 2'd1;
    for (int k = 1; k < 3; k++)
      if (hitm(k, ena, a)) return 2'(k + 1);
    return 2'd0;
  endfunction

  initial begin
    // Directed sequence: reset, forwarding distances, x0, load-use, redirect, mem wait, overlap.
    addv(0,1, 0,0,0,0, 1,5,0, 1,0, 6'b000000, 0,0,0,0);
    addv(1,1, 0,0,0,0, 1,5,0, 0,0, 6'b000000, 0,0,0,0);
    addv(1,1, 1,5,1,5, 1,6,0, 0,0, 6'b000000, 1,1,0,0);
    addv(1,1, 0,0,0,0, 1,9,0, 0,0, 6'b000000, 0,0,0,0);
    addv(1,1, 1,5,1,6, 0,0,0, 0,0, 6'b000000, 3,2,0,0);
    addv(1,1, 1,0,1,9, 0,0,0, 0,0, 6'b000000, 0,2,0,0);
    addv(1,1, 0,0,0,0, 1,0,0, 0,0, 6'b000000, 0,0,0,0);
    addv(1,1, 1,0,1,0, 0,0,0, 0,0, 6'b000000, 0,0,0,0);
    addv(1,1, 0,0,0,0, 1,7,1, 0,0, 6'b000000, 0,0,0,0);
    addv(1,1, 1,7,1,1, 1,8,0, 0,0, 6'b111000, 0,0,0,0);
    addv(1,1, 1,7,1,1, 1,8,0, 0,0, 6'b000000, 2,0,1,1);
    addv(1,1, 1,8,0,0, 1,3,0, 1,0, 6'b001100, 1,0,0,1);
    addv(1,1, 0,0,0,0, 1,4,0, 0,0, 6'b001010, 0,0,3,1);
    addv(1,1, 1,3,1,4, 1,10,0, 0,0, 6'b000000, 0,0,0,1);
    addv(0,0, 0,0,0,0, 0,0,0, 0,0, 6'b000000, 0,0,0,1);
    addv(1,1, 0,0,0,0, 1,7,1, 0,0, 6'b000000, 0,0,0,0);
    addv(1,1, 1,7,0,0, 1,8,0, 0,1, 6'b110001, 0,0,0,0);
    addv(1,1, 1,7,0,0, 1,8,0, 0,1, 6'b110001, 0,0,2,1);
    addv(1,1, 1,7,0,0, 1,8,0, 0,1, 6'b110001, 0,0,2,2);
    addv(1,1, 1,7,0,0, 1,8,0, 0,0, 6'b111000, 0,0,2,3);
    addv(1,1, 1,7,0,0, 1,8,0, 0,0, 6'b000000, 2,0,1,4);
    addv(1,1, 0,0,0,0, 1,3,0, 1,1, 6'b110001, 0,0,0,4);
    addv(1,1, 0,0,0,0, 1,3,0, 1,0, 6'b001100, 0,0,2,5);
    addv(1,1, 0,0,0,0, 1,4,0, 0,0, 6'b001010, 0,0,3,5);
    addv(1,0, 0,0,0,0, 0,0,0, 0,0, 6'b000000, 0,0,0,5);

    drive(0,0,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].e1, vecs[i].a1, vecs[i].e2, vecs[i].a2,
            vecs[i].rde, vecs[i].rd, vecs[i].ld, vecs[i].redir, vecs[i].busy);
      @(negedge clk);
      chk("vec_flags", i, 32'(dut_flags()), 32'(vecs[i].flags));
      chk("vec_fwd",   i, {28'd0, ifm.fwd_rs1, ifm.fwd_rs2}, {28'd0, vecs[i].f1, vecs[i].f2});
      chk("vec_state", i, 32'(ifm.ctrl_state), 32'(vecs[i].st));
      chk("vec_cnt",   i, ifm.stall_cnt, 32'(vecs[i].cnt));
      @(posedge clk); #1;
    end

    // Saturation: 20 busy cycles after reset; the 4-bit counter must stick at 15.
    drive(0,0,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      drive(1,0,0,0,0,0,0,0,0,0,1);
      @(negedge clk);
      if (i == 14 || i == 15) chk("sat_cnt4", i, 32'(ifs.stall_cnt), 32'(i));
      @(posedge clk); #1;
    end
    drive(1,0,0,0,0,0,0,0,0,0,0);
    @(negedge clk);
    chk("sat_cnt4_final", 20, 32'(ifs.stall_cnt), 32'd15);
    chk("sat_cnt32_final", 20, ifm.stall_cnt, 32'd20);
    @(posedge clk); #1;

    // Randomized run against the behavioural model.
    m_state = 0; m_cnt = 0; m_cnt4 = 0;
    for (int k = 0; k < 3; k++) sb[k] = '{default: 0};
    drive(0,0,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    for (int i = 0; i < 1500; i++) begin
      bit r, v, e1, e2, rde, ld, redir, busy, lu, issue;
      bit [4:0] a1, a2, rd;
      bit [5:0] ef;
      bit [1:0] ef1, ef2;
      int nstate;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 99) < 85);
      e1 = $urandom_range(0, 1);  a1 = 5'($urandom_range(0, 3));
      e2 = $urandom_range(0, 1);  a2 = 5'($urandom_range(0, 3));
      rde = ($urandom_range(0, 99) < 70); rd = 5'($urandom_range(0, 3));
      ld = ($urandom_range(0, 99) < 30);
      redir = ($urandom_range(0, 99) < 8);
      busy = ($urandom_range(0, 99) < 15);
      drive(r, v, e1, a1, e2, a2, rde, rd, ld, redir, busy);

      lu = sb[0].ld && (hitm(0, e1, a1) || hitm(0, e2, a2));
      ef = 6'b000000; ef1 = 2'd0; ef2 = 2'd0;
      if (r) begin
        ef1 = fwdm(e1, a1);
        ef2 = fwdm(e2, a2);
        if (busy)              ef = 6'b110001;
        else if (redir)        ef = 6'b001100;
        else if (m_state == 3) ef = 6'b001010;
        else if (lu)           ef = 6'b111000;
      end

      @(negedge clk);
      chk("rnd_flags", i, 32'(dut_flags()), 32'(ef));
      chk("rnd_fwd1",  i, 32'(ifm.fwd_rs1), 32'(ef1));
      chk("rnd_fwd2",  i, 32'(ifm.fwd_rs2), 32'(ef2));
      chk("rnd_state", i, 32'(ifm.ctrl_state), 32'(m_state));
      chk("rnd_cnt",   i, ifm.stall_cnt, 32'(m_cnt));
      chk("rnd_cnt4",  i, 32'(ifs.stall_cnt), 32'(m_cnt4));
      @(posedge clk);

      if (!r) begin
        for (int k = 0; k < 3; k++) sb[k] = '{default: 0};
        m_state = 0; m_cnt = 0; m_cnt4 = 0;
      end else begin
        if (ef[4]) begin
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        nstate = busy ? 2 : (redir ? 3 : (lu ? 1 : 0));
        if (!busy) begin
          issue = v && rde && !lu && !redir && (m_state != 3);
          sb[2] = sb[1];
          sb[1] = sb[0];
          sb[0].v = issue;
          sb[0].rd = issue ? rd : 5'd0;
          sb[0].ld = issue ? ld : 1'b0;
        end
        m_state = nstate;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
